// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI transaction scheduler.
//   - spi_state_t : scheduler FSM states
//   - CFG_*       : bit positions of the fields in the config byte
//   - DEFAULT_TIMEOUT : default per-phase ready-wait limit (clk cycles)
//   - cfg_pack()  : builds a config byte {mode,len,cpol,cpha,div[2:0],1'b0}
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_CFG_DRV,
    S_CFG_WAIT,
    S_TX_DRV,
    S_TX_WAIT,
    S_CAPTURE,
    S_DONE
  } spi_state_t;

  localparam int unsigned CFG_MODE_BIT = 7;
  localparam int unsigned CFG_LEN_BIT  = 6;
  localparam int unsigned CFG_CPOL_BIT = 5;
  localparam int unsigned CFG_CPHA_BIT = 4;
  localparam int unsigned CFG_DIV_MSB  = 3;
  localparam int unsigned CFG_DIV_LSB  = 1;

  localparam int unsigned DEFAULT_TIMEOUT = 4096;

  function automatic logic [7:0] cfg_pack(input logic       mode,
                                          input logic       len,
                                          input logic       cpol,
                                          input logic       cpha,
                                          input logic [2:0] div);
    logic [7:0] r;
    r = '0;
    r[CFG_MODE_BIT] = mode;
    r[CFG_LEN_BIT]  = len;
    r[CFG_CPOL_BIT] = cpol;
    r[CFG_CPHA_BIT] = cpha;
    r[CFG_DIV_MSB:CFG_DIV_LSB] = div;
    return r;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: combinational round-robin pick.
//   req        in  NUM_REQ  request levels
//   rr_ptr     in  IDW      index of the last granted requester
//   pick_onehot out NUM_REQ one-hot of the selected requester
//   pick_id    out IDW      index of the selected requester
//   pick_valid out 1        at least one request present
// Scan order is rr_ptr+1, rr_ptr+2, ... wrapping, so rr_ptr itself is last.
module spi_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [IDW-1:0]     pick_id,
  output logic               pick_valid
);

  int unsigned      idx;
  logic [IDW-1:0]   idx_n;

  always_comb begin
    pick_onehot = '0;
    pick_id     = '0;
    pick_valid  = 1'b0;
    idx         = 0;
    idx_n       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx   = (32'(rr_ptr) + k) % NUM_REQ;
      idx_n = idx[IDW-1:0];
      if (!pick_valid && req[idx_n]) begin
        pick_onehot[idx_n] = 1'b1;
        pick_id            = idx_n;
        pick_valid         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: round-robin sharing of one SPI core between NUM_REQ
// requesters. Per grant: optional config byte, TX byte, RX byte capture.
//   clk, rst        clock, synchronous active-high reset
//   req             per-requester request level (held until its done)
//   cfg_in, tx_in   per-requester config / TX byte, slice i = [8i+7:8i]
//   gnt             one-hot grant, ARB exit through DONE
//   done/done_id    one-cycle completion pulse and requester index
//   rx_out          received byte (held until the next successful done)
//   err             with done: 1 = a phase timed out
//   core_data_o/oe  byte and drive enable onto the core bus
//   core_data_i     core bus readback
//   core_ready      core ready level
module spi_txn_scheduler
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] cfg_in,
  input  logic [8*NUM_REQ-1:0] tx_in,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 done,
  output logic [IDW-1:0]       done_id,
  output logic [7:0]           rx_out,
  output logic                 err,
  output logic [7:0]           core_data_o,
  output logic                 core_data_oe,
  input  logic [7:0]           core_data_i,
  input  logic                 core_ready
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  spi_state_t         state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     cur_id;
  logic [7:0]         cur_cfg;
  logic [7:0]         cur_tx;
  logic [7:0]         last_cfg;
  logic               cfg_valid;
  logic [TW-1:0]      timer;
  logic               seen_low;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDW-1:0]     pick_id;
  logic               pick_valid;
  logic [7:0]         pick_cfg;
  logic [7:0]         pick_tx;
  logic               phase_ok;
  logic               phase_expired;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .pick_onehot (pick_onehot),
    .pick_id     (pick_id),
    .pick_valid  (pick_valid)
  );

  always_comb begin
    pick_cfg = '0;
    pick_tx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_id == IDW'(i)) begin
        pick_cfg = cfg_in[8*i +: 8];
        pick_tx  = tx_in[8*i +: 8];
      end
    end
  end

  // Phase completes on a rising edge of core_ready: it must have been
  // sampled low at least once since the phase was entered.
  assign phase_ok      = core_ready && seen_low;
  assign phase_expired = (timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rr_ptr       <= IDW'(NUM_REQ - 1);
      cur_id       <= '0;
      cur_cfg      <= '0;
      cur_tx       <= '0;
      last_cfg     <= '0;
      cfg_valid    <= 1'b0;
      timer        <= '0;
      seen_low     <= 1'b0;
      gnt          <= '0;
      done         <= 1'b0;
      done_id      <= '0;
      rx_out       <= '0;
      err          <= 1'b0;
      core_data_o  <= '0;
      core_data_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) state <= S_ARB;
        end

        S_ARB: begin
          if (pick_valid) begin
            cur_id  <= pick_id;
            cur_cfg <= pick_cfg;
            cur_tx  <= pick_tx;
            gnt     <= pick_onehot;
            rr_ptr  <= pick_id;
            state   <= (cfg_valid && (pick_cfg == last_cfg)) ? S_TX_DRV : S_CFG_DRV;
          end else begin
            state <= S_IDLE;
          end
        end

        S_CFG_DRV: begin
          core_data_o  <= cur_cfg;
          core_data_oe <= 1'b1;
          timer        <= '0;
          seen_low     <= 1'b0;
          state        <= S_CFG_WAIT;
        end

        S_CFG_WAIT: begin
          if (phase_ok) begin
            last_cfg     <= cur_cfg;
            cfg_valid    <= 1'b1;
            core_data_oe <= 1'b0;
            state        <= S_TX_DRV;
          end else if (phase_expired) begin
            core_data_oe <= 1'b0;
            cfg_valid    <= 1'b0;
            done         <= 1'b1;
            done_id      <= cur_id;
            err          <= 1'b1;
            state        <= S_DONE;
          end else begin
            timer <= timer + TW'(1);
            if (!core_ready) seen_low <= 1'b1;
          end
        end

        S_TX_DRV: begin
          core_data_o  <= cur_tx;
          core_data_oe <= 1'b1;
          timer        <= '0;
          seen_low     <= 1'b0;
          state        <= S_TX_WAIT;
        end

        S_TX_WAIT: begin
          if (phase_ok) begin
            core_data_oe <= 1'b0;
            state        <= S_CAPTURE;
          end else if (phase_expired) begin
            core_data_oe <= 1'b0;
            cfg_valid    <= 1'b0;
            done         <= 1'b1;
            done_id      <= cur_id;
            err          <= 1'b1;
            state        <= S_DONE;
          end else begin
            timer <= timer + TW'(1);
            if (!core_ready) seen_low <= 1'b1;
          end
        end

        S_CAPTURE: begin
          rx_out  <= core_data_i;
          done    <= 1'b1;
          done_id <= cur_id;
          err     <= 1'b0;
          state   <= S_DONE;
        end

        S_DONE: begin
          gnt   <= '0;
          err   <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
module tb_spi_txn_scheduler;
  import spi_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TMO  = 64;
  localparam int unsigned IDW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [8*NREQ-1:0] cfg_in;
  logic [8*NREQ-1:0] tx_in;
  logic [NREQ-1:0] gnt;
  logic            done;
  logic [IDW-1:0]  done_id;
  logic [7:0]      rx_out;
  logic            err;
  logic [7:0]      core_data_o;
  logic            core_data_oe;
  logic [7:0]      core_data_i;
  logic            core_ready;

  always #5 clk = ~clk;

  spi_txn_scheduler #(
    .NUM_REQ (NREQ),
    .TIMEOUT (TMO),
    .IDW     (IDW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .cfg_in       (cfg_in),
    .tx_in        (tx_in),
    .gnt          (gnt),
    .done         (done),
    .done_id      (done_id),
    .rx_out       (rx_out),
    .err          (err),
    .core_data_o  (core_data_o),
    .core_data_oe (core_data_oe),
    .core_data_i  (core_data_i),
    .core_ready   (core_ready)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [7:0]     rx;
    logic           err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] bus_log[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt = 0;
  int         lo_cycles = 1;
  logic       stuck = 1'b0;
  int         t1_cycles = 0;

  // Core model: on each new bus drive, pull ready low for lo_cycles clocks
  // then raise it; ready is high whenever the bus is released.
  initial begin
    int   lo_left;
    logic prev_oe;
    core_ready = 1'b1;
    lo_left    = 0;
    prev_oe    = 1'b0;
    forever begin
      @(negedge clk);
      if (core_data_oe === 1'b1 && prev_oe !== 1'b1) begin
        bus_log.push_back(core_data_o);
        if (!stuck) begin
          core_ready = 1'b0;
          lo_left    = lo_cycles;
        end
      end else if (core_data_oe !== 1'b1) begin
        core_ready = 1'b1;
        lo_left    = 0;
      end else if (lo_left > 0) begin
        lo_left--;
        if (lo_left == 0) core_ready = 1'b1;
      end
      prev_oe = core_data_oe;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic set_slot(input int i, input logic [7:0] c, input logic [7:0] t);
    cfg_in[8*i +: 8] = c;
    tx_in[8*i +: 8]  = t;
  endtask

  task automatic wait_done(input int budget, output logic got, output logic [IDW-1:0] id,
                           output logic [7:0] rx, output logic e, output logic [NREQ-1:0] g,
                           output int cycles);
    got = 1'b0; id = '0; rx = '0; e = 1'b0; g = '0; cycles = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) begin
        got = 1'b1; id = done_id; rx = rx_out; e = err; g = gnt;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; cfg_in = '0; tx_in = '0; core_data_i = '0;
    repeat (3) @(negedge clk);
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    vectors++; if ({done, err, core_data_oe} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got=%b exp=000", {done, err, core_data_oe}); end
    vectors++; if ({done_id, rx_out, core_data_o} !== 18'h0) begin miscompares++; $display("FAIL rst_data got=%h exp=0", {done_id, rx_out, core_data_o}); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic got, e; logic [IDW-1:0] id; logic [7:0] rx; logic [NREQ-1:0] g; int cyc; exp_t ex;
    lo_cycles = 2; core_data_i = 8'hAA;
    set_slot(0, cfg_pack(1'b0, 1'b0, 1'b0, 1'b0, 3'b001), 8'hA5);
    bus_log.delete();
    sb.push_back('{id: 2'd0, rx: 8'hAA, err: 1'b0});
    req = 4'b0001;
    wait_done(200, got, id, rx, e, g, cyc);
    req = 4'b0000;
    ex = sb.pop_front();
    t1_cycles = cyc;
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL t1_done got=%b exp=1", got); end
    vectors++; if (id !== ex.id) begin miscompares++; $display("FAIL t1_id got=%0d exp=%0d", id, ex.id); end
    vectors++; if (rx !== ex.rx) begin miscompares++; $display("FAIL t1_rx got=%h exp=%h", rx, ex.rx); end
    vectors++; if (e !== ex.err) begin miscompares++; $display("FAIL t1_err got=%b exp=%b", e, ex.err); end
    vectors++; if (g !== 4'b0001) begin miscompares++; $display("FAIL t1_gnt got=%b exp=0001", g); end
    vectors++; if (cyc !== 11) begin miscompares++; $display("FAIL t1_latency got=%0d exp=11", cyc); end
    vectors++; if (bus_log.size() !== 2) begin miscompares++; $display("FAIL t1_bus_count got=%0d exp=2", bus_log.size()); end
    vectors++; if (((bus_log.size() > 0) ? bus_log[0] : 8'h00) !== 8'h02) begin miscompares++; $display("FAIL t1_bus_cfg got=%h exp=02", (bus_log.size() > 0) ? bus_log[0] : 8'h00); end
    vectors++; if (((bus_log.size() > 1) ? bus_log[1] : 8'h00) !== 8'hA5) begin miscompares++; $display("FAIL t1_bus_tx got=%h exp=a5", (bus_log.size() > 1) ? bus_log[1] : 8'h00); end
    @(negedge clk);
    vectors++; if ({done, gnt} !== 5'b0) begin miscompares++; $display("FAIL t1_after_done got=%b exp=00000", {done, gnt}); end
  endtask

  task automatic test_cached();
    logic got, e; logic [IDW-1:0] id; logic [7:0] rx; logic [NREQ-1:0] g; int cyc; exp_t ex;
    repeat (2) @(negedge clk);
    lo_cycles = 2; core_data_i = 8'h3C;
    bus_log.delete();
    sb.push_back('{id: 2'd0, rx: 8'h3C, err: 1'b0});
    req = 4'b0001;
    wait_done(200, got, id, rx, e, g, cyc);
    req = 4'b0000;
    ex = sb.pop_front();
    vectors++; if ({got, id, rx, e} !== {1'b1, ex.id, ex.rx, ex.err}) begin miscompares++; $display("FAIL t2_result got=%h exp=%h", {got, id, rx, e}, {1'b1, ex.id, ex.rx, ex.err}); end
    vectors++; if (cyc !== 7) begin miscompares++; $display("FAIL t2_latency got=%0d exp=7", cyc); end
    vectors++; if (!(t1_cycles - cyc >= 3)) begin miscompares++; $display("FAIL t2_saving got=%0d exp>=3", t1_cycles - cyc); end
    vectors++; if (bus_log.size() !== 1) begin miscompares++; $display("FAIL t2_bus_count got=%0d exp=1", bus_log.size()); end
    vectors++; if (((bus_log.size() > 0) ? bus_log[0] : 8'h00) !== 8'hA5) begin miscompares++; $display("FAIL t2_bus_tx got=%h exp=a5", (bus_log.size() > 0) ? bus_log[0] : 8'h00); end
  endtask

  task automatic test_latency();
    logic got, e; logic [IDW-1:0] id; logic [7:0] rx; logic [NREQ-1:0] g; int cyc; exp_t ex;
    repeat (2) @(negedge clk);
    lo_cycles = 1; core_data_i = 8'hC3;
    set_slot(0, 8'h02, 8'h5A);
    sb.push_back('{id: 2'd0, rx: 8'hC3, err: 1'b0});
    req = 4'b0001;
    wait_done(100, got, id, rx, e, g, cyc);
    req = 4'b0000;
    ex = sb.pop_front();
    vectors++; if ({got, id, rx, e} !== {1'b1, ex.id, ex.rx, ex.err}) begin miscompares++; $display("FAIL lat_result got=%h exp=%h", {got, id, rx, e}, {1'b1, ex.id, ex.rx, ex.err}); end
    vectors++; if (cyc !== 6) begin miscompares++; $display("FAIL lat_cached got=%0d exp=6", cyc); end
  endtask

  task automatic test_round_robin();
    logic got, e; logic [IDW-1:0] id; logic [7:0] rx; logic [NREQ-1:0] g; int cyc; exp_t ex;
    logic [7:0] last_b;
    repeat (2) @(negedge clk);
    pulse_reset();
    lo_cycles = 1; core_data_i = 8'h60;
    for (int i = 0; i < 4; i++) set_slot(i, 8'h02, 8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) sb.push_back('{id: 2'(i), rx: 8'h60, err: 1'b0});
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        repeat (3) @(negedge clk);
        sb.push_back('{id: 2'd0, rx: 8'h60, err: 1'b0});
        sb.push_back('{id: 2'd2, rx: 8'h60, err: 1'b0});
        req = 4'b0101;
      end
      bus_log.delete();
      wait_done(100, got, id, rx, e, g, cyc);
      if (got) req[id] = 1'b0;
      ex = sb.pop_front();
      last_b = (bus_log.size() > 0) ? bus_log[bus_log.size()-1] : 8'h00;
      vectors++; if ({got, id, e} !== {1'b1, ex.id, ex.err}) begin miscompares++; $display("FAIL rr_order k=%0d got=%h exp=%h", k, {got, id, e}, {1'b1, ex.id, ex.err}); end
      vectors++; if (g !== (4'b0001 << ex.id)) begin miscompares++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, g, 4'b0001 << ex.id); end
      vectors++; if (last_b !== 8'h10 + 8'(ex.id)) begin miscompares++; $display("FAIL rr_tx k=%0d got=%h exp=%h", k, last_b, 8'h10 + 8'(ex.id)); end
    end
  endtask

  task automatic test_timeout();
    logic got, e; logic [IDW-1:0] id; logic [7:0] rx; logic [NREQ-1:0] g; int cyc; exp_t ex;
    repeat (2) @(negedge clk);
    set_slot(0, cfg_pack(1'b1, 1'b0, 1'b0, 1'b0, 3'b000), 8'h77);
    stuck = 1'b1; core_data_i = 8'h55;
    sb.push_back('{id: 2'd0, rx: 8'h60, err: 1'b1});
    req = 4'b0001;
    wait_done(TMO + 40, got, id, rx, e, g, cyc);
    req = 4'b0000;
    ex = sb.pop_front();
    vectors++; if ({got, id, e} !== {1'b1, ex.id, ex.err}) begin miscompares++; $display("FAIL to_err got=%h exp=%h", {got, id, e}, {1'b1, ex.id, ex.err}); end
    vectors++; if (rx !== ex.rx) begin miscompares++; $display("FAIL to_rx_held got=%h exp=%h", rx, ex.rx); end
    vectors++; if (cyc !== TMO + 3) begin miscompares++; $display("FAIL to_latency got=%0d exp=%0d", cyc, TMO + 3); end
    vectors++; if (core_data_oe !== 1'b0) begin miscompares++; $display("FAIL to_bus_release got=%b exp=0", core_data_oe); end
    repeat (2) @(negedge clk);
    stuck = 1'b0; lo_cycles = 1;
    bus_log.delete();
    sb.push_back('{id: 2'd0, rx: 8'h55, err: 1'b0});
    req = 4'b0001;
    wait_done(100, got, id, rx, e, g, cyc);
    req = 4'b0000;
    ex = sb.pop_front();
    vectors++; if ({got, id, rx, e} !== {1'b1, ex.id, ex.rx, ex.err}) begin miscompares++; $display("FAIL to_retry got=%h exp=%h", {got, id, rx, e}, {1'b1, ex.id, ex.rx, ex.err}); end
    vectors++; if (((bus_log.size() > 0) ? bus_log[0] : 8'h00) !== 8'h80) begin miscompares++; $display("FAIL to_cfg_resent got=%h exp=80", (bus_log.size() > 0) ? bus_log[0] : 8'h00); end
    vectors++; if (cyc !== 9) begin miscompares++; $display("FAIL to_retry_latency got=%0d exp=9", cyc); end
  endtask

  task automatic test_reset_mid();
    logic got, e; logic [IDW-1:0] id; logic [7:0] rx; logic [NREQ-1:0] g; int cyc; exp_t ex;
    int d0; logic seen_oe;
    repeat (2) @(negedge clk);
    lo_cycles = 30; core_data_i = 8'h99;
    req = 4'b0001;
    seen_oe = 1'b0;
    for (int n = 0; n < 20 && !seen_oe; n++) begin
      @(negedge clk);
      if (core_data_oe === 1'b1) seen_oe = 1'b1;
    end
    vectors++; if (seen_oe !== 1'b1) begin miscompares++; $display("FAIL rm_reach_wait got=%b exp=1", seen_oe); end
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1; req = 4'b0000;
    @(negedge clk);
    vectors++; if ({gnt, done, err, core_data_oe} !== 7'b0) begin miscompares++; $display("FAIL rm_ctrl got=%b exp=0000000", {gnt, done, err, core_data_oe}); end
    vectors++; if ({done_id, rx_out, core_data_o} !== 18'h0) begin miscompares++; $display("FAIL rm_data got=%h exp=0", {done_id, rx_out, core_data_o}); end
    rst = 1'b0; lo_cycles = 1;
    repeat (5) @(negedge clk);
    vectors++; if (done_cnt !== d0) begin miscompares++; $display("FAIL rm_no_done got=%0d exp=%0d", done_cnt, d0); end
    bus_log.delete();
    sb.push_back('{id: 2'd0, rx: 8'h99, err: 1'b0});
    sb.push_back('{id: 2'd2, rx: 8'h99, err: 1'b0});
    req = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      wait_done(100, got, id, rx, e, g, cyc);
      if (got) req[id] = 1'b0;
      ex = sb.pop_front();
      vectors++; if ({got, id, rx, e} !== {1'b1, ex.id, ex.rx, ex.err}) begin miscompares++; $display("FAIL rm_restart k=%0d got=%h exp=%h", k, {got, id, rx, e}, {1'b1, ex.id, ex.rx, ex.err}); end
      if (k == 0) begin
        vectors++; if (((bus_log.size() > 0) ? bus_log[0] : 8'h00) !== 8'h80) begin miscompares++; $display("FAIL rm_cfg_resent got=%h exp=80", (bus_log.size() > 0) ? bus_log[0] : 8'h00); end
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_drop_in_arb();
    int d0; logic saw_gnt, saw_oe;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    saw_gnt = 1'b0; saw_oe = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (gnt !== 4'b0000) saw_gnt = 1'b1;
      if (core_data_oe !== 1'b0) saw_oe = 1'b1;
    end
    vectors++; if (saw_gnt !== 1'b0) begin miscompares++; $display("FAIL drop_gnt got=%b exp=0", saw_gnt); end
    vectors++; if (saw_oe !== 1'b0) begin miscompares++; $display("FAIL drop_bus got=%b exp=0", saw_oe); end
    vectors++; if (done_cnt !== d0) begin miscompares++; $display("FAIL drop_no_done got=%0d exp=%0d", done_cnt, d0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_cached();
    test_latency();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_drop_in_arb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
